// File: rtl/mem_initiator_pkg.sv
// Shared definitions for the PCI user-app memory initiator.
// Contents: FSM state encoding, PCI bus command codes, retry limit and a
// helper that maps transfer direction to the bus command.
package mem_initiator_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_DATA,
    S_TERM,
    S_FIN
  } state_t;

  localparam logic [3:0] CMD_MEM_READ  = 4'h6;
  localparam logic [3:0] CMD_MEM_WRITE = 4'h7;

  // Number of bus requests allowed before the transfer is declared failed.
  localparam int RETRY_LIMIT = 8;
  localparam int RETRY_W     = 4;

  function automatic logic [3:0] pci_cmd(input logic wrdn);
    return wrdn ? CMD_MEM_WRITE : CMD_MEM_READ;
  endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// Handshake bundle between the memory initiator and the PCI core.
// master: initiator side (drives request/m_wrdn/m_cbe/m_ready/complete)
// slave : core side (drives m_addr_n/m_data/m_data_vld/m_src_en/m_abort/adio_out)
// The tri-state adio_in bus is kept as a plain port on the initiator.
interface mem_initiator_if;
  logic        request;
  logic        m_wrdn;
  logic [3:0]  m_cbe;
  logic        m_ready;
  logic        complete;
  logic        m_addr_n;
  logic        m_data;
  logic        m_data_vld;
  logic        m_src_en;
  logic        m_abort;
  logic [31:0] adio_out;

  modport master (
    output request, m_wrdn, m_cbe, m_ready, complete,
    input  m_addr_n, m_data, m_data_vld, m_src_en, m_abort, adio_out
  );

  modport slave (
    input  request, m_wrdn, m_cbe, m_ready, complete,
    output m_addr_n, m_data, m_data_vld, m_src_en, m_abort, adio_out
  );
endinterface

// File: rtl/mem_initiator_buf.sv
// Local transfer buffer: 2^AW x 32 words.
// Ports:
//   clk                  clock
//   i_bus_we/addr/wdata  bus-side write (read-data store), wins collisions
//   o_bus_rdata          bus-side combinational read at i_bus_addr
//   i_loc_we/addr/wdata  local-side write
//   o_loc_rdata          local-side read at i_loc_addr, one-cycle latency
module mem_initiator_buf #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          i_bus_we,
  input  logic [AW-1:0] i_bus_addr,
  input  logic [31:0]   i_bus_wdata,
  output logic [31:0]   o_bus_rdata,
  input  logic          i_loc_we,
  input  logic [AW-1:0] i_loc_addr,
  input  logic [31:0]   i_loc_wdata,
  output logic [31:0]   o_loc_rdata
);

  logic [31:0] r_mem [2**AW];

  // NOTE: storage is deliberately not reset; contents are undefined after
  // reset, which keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (i_loc_we) r_mem[i_loc_addr] <= i_loc_wdata;
    // Issued after the local write so a same-index collision keeps bus data.
    if (i_bus_we) r_mem[i_bus_addr] <= i_bus_wdata;
    o_loc_rdata <= r_mem[i_loc_addr];
  end

  // Write data must be on adio_in in the same cycle the core consumes it.
  assign o_bus_rdata = r_mem[i_bus_addr];

endmodule

// File: rtl/mem_initiator.sv
// PCI memory-burst initiator. Moves 1..2^BUF_AW words between a local
// buffer and PCI memory, retrying on disconnect and failing on abort or
// after RETRY_LIMIT requests.
// Ports:
//   CLK, reset_n           clock, async active-low reset
//   start/start_wrdn/start_addr/start_len   transfer launch (IDLE only)
//   busy, done, err        status; done pulses once, err valid with done
//   buf_we/addr/wdata/rdata  local buffer access
//   bus                    PCI core handshake (master modport)
//   adio_in                address/write data to core, high-Z when idle
module mem_initiator
  import mem_initiator_pkg::*;
#(
  parameter int BUF_AW = 4
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              start,
  input  logic              start_wrdn,
  input  logic [31:0]       start_addr,
  input  logic [BUF_AW:0]   start_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              buf_we,
  input  logic [BUF_AW-1:0] buf_addr,
  input  logic [31:0]       buf_wdata,
  output logic [31:0]       buf_rdata,
  mem_initiator_if.master   bus,
  output wire  [31:0]       adio_in
);

  state_t            r_state;
  logic              r_wrdn;
  logic [29:0]       r_base;
  logic [BUF_AW:0]   r_len;
  logic [BUF_AW:0]   r_idx;
  logic [RETRY_W-1:0] r_retry;
  logic              r_err;

  logic              w_beat;
  logic [BUF_AW:0]   w_idx_nxt;
  logic [29:0]       w_cur_addr;
  logic [31:0]       w_buf_bus_rdata;
  logic              w_bus_we;
  logic              w_unused;

  assign w_unused = ^start_addr[1:0];

  // A beat never advances past the programmed length, even if the core
  // over-transfers.
  assign w_beat    = (r_state == S_DATA) && (r_idx != r_len) &&
                     (r_wrdn ? bus.m_src_en : bus.m_data_vld);
  assign w_idx_nxt = r_idx + (BUF_AW+1)'(w_beat);
  assign w_cur_addr = r_base + 30'(r_idx);
  assign w_bus_we  = w_beat && !r_wrdn;

  mem_initiator_buf #(.AW(BUF_AW)) u_buf (
    .clk         (CLK),
    .i_bus_we    (w_bus_we),
    .i_bus_addr  (r_idx[BUF_AW-1:0]),
    .i_bus_wdata (bus.adio_out),
    .o_bus_rdata (w_buf_bus_rdata),
    .i_loc_we    (buf_we),
    .i_loc_addr  (buf_addr),
    .i_loc_wdata (buf_wdata),
    .o_loc_rdata (buf_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_wrdn  <= 1'b0;
      r_base  <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_retry <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base  <= start_addr[31:2];
            r_len   <= (start_len == '0) ? {1'b1, {BUF_AW{1'b0}}} : start_len;
            r_wrdn  <= start_wrdn;
            r_idx   <= '0;
            r_retry <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.m_abort) begin
            r_err   <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (bus.m_abort) begin
            r_err   <= 1'b1;
            r_state <= S_FIN;
          end else if (bus.m_data) begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          r_idx <= w_idx_nxt;
          if (bus.m_abort) begin
            r_err   <= 1'b1;
            r_state <= S_FIN;
          end else if (!bus.m_data) begin
            if (w_idx_nxt == r_len) begin
              r_err   <= 1'b0;
              r_state <= S_FIN;
            end else begin
              r_state <= S_TERM;
            end
          end
        end
        S_TERM: begin
          // Disconnect or retry: resume at r_idx with a fresh request.
          r_retry <= r_retry + RETRY_W'(1);
          if (r_retry == RETRY_W'(RETRY_LIMIT - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode directly from registered state.
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_FIN);
  assign err  = done && r_err;

  assign bus.request  = (r_state == S_REQ);
  assign bus.m_wrdn   = busy && r_wrdn;
  assign bus.m_cbe    = busy ? pci_cmd(r_wrdn) : 4'h0;
  assign bus.m_ready  = (r_state == S_DATA);
  // Once remaining <= 1 it stays so for the rest of the data phase.
  assign bus.complete = (r_state == S_DATA) &&
                        ((r_len - r_idx) <= (BUF_AW+1)'(1));

  assign adio_in = ((r_state == S_ADDR) && !bus.m_addr_n) ? {w_cur_addr, 2'b00} :
                   ((r_state == S_DATA) && r_wrdn)        ? w_buf_bus_rdata     :
                                                            32'bz;

endmodule

// File: tb/tb_mem_initiator.sv
module tb_mem_initiator;
  logic        CLK;
  logic        reset_n;
  logic        start;
  logic        start_wrdn;
  logic [31:0] start_addr;
  logic [4:0]  start_len;
  logic        busy, done, err;
  logic        buf_we;
  logic [3:0]  buf_addr;
  logic [31:0] buf_wdata;
  logic [31:0] buf_rdata;
  wire  [31:0] adio_in;

  mem_initiator_if u_if ();

  mem_initiator #(.BUF_AW(4)) dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .start      (start),
    .start_wrdn (start_wrdn),
    .start_addr (start_addr),
    .start_len  (start_len),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .buf_we     (buf_we),
    .buf_addr   (buf_addr),
    .buf_wdata  (buf_wdata),
    .buf_rdata  (buf_rdata),
    .bus        (u_if.master),
    .adio_in    (adio_in)
  );

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int done_cnt = 0;
  logic [31:0] wbuf [16];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (u_if.request === 1'b1) req_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic clear_bus();
    u_if.m_addr_n   = 1'b1;
    u_if.m_data     = 1'b0;
    u_if.m_data_vld = 1'b0;
    u_if.m_src_en   = 1'b0;
    u_if.m_abort    = 1'b0;
    u_if.adio_out   = '0;
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      buf_we = 1'b1; buf_addr = 4'(i); buf_wdata = base + 32'(i);
      wbuf[i] = base + 32'(i);
    end
    @(negedge CLK);
    buf_we = 1'b0;
  endtask

  task automatic read_buf(input int idx, output logic [31:0] data);
    @(negedge CLK);
    buf_addr = 4'(idx);
    @(negedge CLK);
    data = buf_rdata;
  endtask

  task automatic launch(input logic wr, input logic [31:0] addr, input logic [4:0] len);
    @(negedge CLK);
    start = 1'b1; start_wrdn = wr; start_addr = addr; start_len = len;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Core model: waits for request, runs an address phase, then nbeats data
  // beats starting at buffer index first_idx, then drops m_data.
  task automatic serve(input logic wr, input logic [31:0] exp_addr, input int nbeats,
                       input int first_idx, input int len, input logic [31:0] rd_base);
    int cyc = 0;
    logic [3:0] exp_cbe;
    exp_cbe = wr ? 4'h7 : 4'h6;
    while (u_if.request !== 1'b1 && cyc < 10) begin
      @(negedge CLK);
      cyc++;
    end
    checks++;
    if (u_if.request !== 1'b1) begin
      errors++; $display("FAIL req_wait got %b want 1", u_if.request);
    end
    checks++;
    if (u_if.m_cbe !== exp_cbe || u_if.m_wrdn !== wr) begin
      errors++; $display("FAIL cmd got cbe=%h wrdn=%b want cbe=%h wrdn=%b",
                         u_if.m_cbe, u_if.m_wrdn, exp_cbe, wr);
    end
    @(negedge CLK);
    u_if.m_addr_n = 1'b0;
    #1;
    checks++;
    if (adio_in !== exp_addr || u_if.request !== 1'b0) begin
      errors++; $display("FAIL addr_phase got adio=%h req=%b want adio=%h req=0",
                         adio_in, u_if.request, exp_addr);
    end
    @(negedge CLK);
    u_if.m_addr_n = 1'b1;
    u_if.m_data   = 1'b1;
    @(negedge CLK);
    for (int k = 0; k < nbeats; k++) begin
      if (wr) u_if.m_src_en = 1'b1;
      else begin
        u_if.m_data_vld = 1'b1;
        u_if.adio_out   = rd_base + 32'(k);
      end
      #1;
      checks++;
      if (u_if.m_ready !== 1'b1) begin
        errors++; $display("FAIL m_ready beat %0d got %b want 1", k, u_if.m_ready);
      end
      if (wr) begin
        checks++;
        if (adio_in !== wbuf[first_idx + k]) begin
          errors++; $display("FAIL wdata beat %0d got %h want %h", k, adio_in, wbuf[first_idx + k]);
        end
      end
      checks++;
      if (u_if.complete !== ((len - (first_idx + k)) <= 1)) begin
        errors++; $display("FAIL complete beat %0d got %b want %b", k, u_if.complete,
                           ((len - (first_idx + k)) <= 1));
      end
      @(negedge CLK);
    end
    u_if.m_src_en   = 1'b0;
    u_if.m_data_vld = 1'b0;
    u_if.m_data     = 1'b0;
  endtask

  task automatic wait_done(input logic exp_err, input string name);
    int cyc = 0;
    while (done !== 1'b1 && cyc < 10) begin
      @(negedge CLK);
      cyc++;
    end
    checks++;
    if (done !== 1'b1 || err !== exp_err) begin
      errors++; $display("FAIL %s_done got done=%b err=%b want done=1 err=%b", name, done, err, exp_err);
    end
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL %s_idle got busy=%b done=%b want 0 0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({busy, done, err, u_if.request, u_if.m_ready, u_if.complete, u_if.m_wrdn} !== 7'b0 ||
        u_if.m_cbe !== 4'h0) begin
      errors++; $display("FAIL reset_outputs got busy=%b done=%b err=%b req=%b rdy=%b cmp=%b wrdn=%b cbe=%h want all 0",
                         busy, done, err, u_if.request, u_if.m_ready, u_if.complete, u_if.m_wrdn, u_if.m_cbe);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_write_burst();
    fill(32'h1000, 4);
    launch(1'b1, 32'h4000_0000, 5'd4);
    serve(1'b1, 32'h4000_0000, 4, 0, 4, 32'h0);
    wait_done(1'b0, "write");
  endtask

  task automatic test_read_burst();
    logic [31:0] d;
    launch(1'b0, 32'h4000_0010, 5'd2);
    serve(1'b0, 32'h4000_0010, 2, 0, 2, 32'hCAFE_0000);
    wait_done(1'b0, "read");
    for (int i = 0; i < 2; i++) begin
      read_buf(i, d);
      checks++;
      if (d !== 32'hCAFE_0000 + 32'(i)) begin
        errors++; $display("FAIL read_buf%0d got %h want %h", i, d, 32'hCAFE_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_disconnect();
    int base;
    fill(32'h2000, 4);
    base = req_cnt;
    launch(1'b1, 32'h4000_0000, 5'd4);
    serve(1'b1, 32'h4000_0000, 2, 0, 4, 32'h0);
    serve(1'b1, 32'h4000_0008, 2, 2, 4, 32'h0);
    wait_done(1'b0, "disc");
    checks++;
    if (req_cnt - base !== 2) begin
      errors++; $display("FAIL disc_requests got %0d want 2", req_cnt - base);
    end
  endtask

  task automatic test_abort();
    launch(1'b0, 32'h4000_0100, 5'd8);
    serve(1'b0, 32'h4000_0100, 0, 0, 8, 32'h0);
    // serve dropped m_data; re-raise for a data phase with the abort inside.
    u_if.m_data = 1'b1;
    // Current state is DATA (drop not yet sampled); convert drop into abort.
    u_if.m_abort = 1'b1;
    @(negedge CLK);
    u_if.m_abort = 1'b0;
    u_if.m_data  = 1'b0;
    checks++;
    if (done !== 1'b1 || err !== 1'b1) begin
      errors++; $display("FAIL abort_next got done=%b err=%b want 1 1", done, err);
    end
    wait_done(1'b1, "abort");
  endtask

  task automatic test_retry_limit();
    int base;
    base = req_cnt;
    launch(1'b1, 32'h4000_0000, 5'd4);
    for (int r = 0; r < 8; r++) serve(1'b1, 32'h4000_0000, 0, 0, 4, 32'h0);
    wait_done(1'b1, "retry");
    repeat (2) @(negedge CLK);
    checks++;
    if (req_cnt - base !== 8) begin
      errors++; $display("FAIL retry_requests got %0d want 8", req_cnt - base);
    end
  endtask

  task automatic test_reset_mid_len0();
    int base;
    launch(1'b1, 32'h4000_0000, 5'd0);
    @(negedge CLK);
    u_if.m_addr_n = 1'b0;
    @(negedge CLK);
    u_if.m_addr_n = 1'b1;
    u_if.m_data   = 1'b1;
    @(negedge CLK);
    u_if.m_src_en = 1'b1;
    repeat (2) @(negedge CLK);
    u_if.m_src_en = 1'b0;
    base = done_cnt;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, u_if.request, u_if.m_ready, u_if.complete, u_if.m_wrdn} !== 7'b0 ||
        u_if.m_cbe !== 4'h0) begin
      errors++; $display("FAIL midreset_outputs got busy=%b done=%b err=%b rdy=%b cmp=%b wrdn=%b cbe=%h want all 0",
                         busy, done, err, u_if.m_ready, u_if.complete, u_if.m_wrdn, u_if.m_cbe);
    end
    clear_bus();
    repeat (3) @(negedge CLK);
    reset_n = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (done_cnt !== base || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_nodone got dones=%0d busy=%b want %0d 0", done_cnt, busy, base);
    end
    fill(32'h3000, 16);
    launch(1'b1, 32'h4000_0040, 5'd0);
    serve(1'b1, 32'h4000_0040, 16, 0, 16, 32'h0);
    wait_done(1'b0, "len0");
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; start_wrdn = 1'b0; start_addr = '0; start_len = '0;
    buf_we = 1'b0; buf_addr = '0; buf_wdata = '0;
    clear_bus();
    test_reset();
    test_write_burst();
    test_read_burst();
    test_disconnect();
    test_abort();
    test_retry_limit();
    test_reset_mid_len0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
